trace_tx_sequencer: RTL and testbench

Sequences the upload of one captured trace frame (plaintext, key, ciphertext, then the on-chip sensor sample buffer) over the UART transmitter. It sits between the AES/sensor capture logic and the UART TX core, and replaces the hand-written PT/KEY/CT/SEN send states inside the main FSM. After each frame it holds a programmable quiet gap before reporting done, so the power network settles before the next encryption.

---
 rtl/trace_tx_sequencer_pkg.sv | 30 +++
 rtl/trace_tx_sequencer_if.sv | 12 +
 rtl/trace_tx_sequencer_gap_timer.sv | 30 +++
 rtl/trace_tx_sequencer.sv | 114 +++++++++++
 tb/tb_trace_tx_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/trace_tx_sequencer_pkg.sv
// Shared types and constants for the trace frame uploader.
// Header layout is {pt, key, ct}, each field sent MSB byte first.
package trace_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_SEND,
      HDR_WAIT,
      SEN_ADDR,
      SEN_SEND,
      SEN_WAIT,
      GAP
   } state_t;

   localparam int HDR_BYTES = 48;
   localparam int BYTE_W    = 8;
   localparam int FIELD_W   = 128;
   localparam int SHADOW_W  = HDR_BYTES * BYTE_W;

   // Field slots inside the shadow register, counted from the MSB end
   localparam int FLD_PT  = 0;
   localparam int FLD_KEY = 1;
   localparam int FLD_CT  = 2;

   function automatic logic [BYTE_W-1:0] hdr_byte(input logic [SHADOW_W-1:0] sh,
                                                  input logic [5:0]          idx);
      return sh[SHADOW_W-1-BYTE_W*int'(idx) -: BYTE_W];
   endfunction

endpackage

// File: rtl/trace_tx_sequencer_if.sv
// Byte handshake between the sequencer and the UART TX core.
interface trace_tx_sequencer_if;
   import trace_pkg::*;

   logic              tx_dv;
   logic [BYTE_W-1:0] tx_byte;
   logic              tx_done;

   modport master (output tx_dv, output tx_byte, input  tx_done);
   modport slave  (input  tx_dv, input  tx_byte, output tx_done);

endinterface

// File: rtl/trace_tx_sequencer_gap_timer.sv
// Load/decrement counter; expire is high for the single cycle the loaded count reaches zero.
module gap_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;
   logic         run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (load) begin
         cnt <= load_val;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) run <= 1'b0;
         else           cnt <= cnt - W'(1);
      end
   end

   assign expire = run && (cnt == '0);

endmodule

// File: rtl/trace_tx_sequencer.sv
// Uploads one trace frame (pt, key, ct, then SAMPLES sensor bytes) over the UART,
// then waits GAP_CYCLES quiet cycles before pulsing done.
module trace_tx_sequencer
   import trace_pkg::*;
#(
   parameter int SAMPLES    = 1024,
   parameter int ADDR_W     = 10,
   parameter int GAP_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                c10_resetn,
   input  logic                start,
   input  logic [FIELD_W-1:0]  pt,
   input  logic [FIELD_W-1:0]  key,
   input  logic [FIELD_W-1:0]  ct,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [BYTE_W-1:0]   mem_rdata,
   trace_tx_sequencer_if.master uart,
   output logic                busy,
   output logic                done,
   output logic [15:0]         frame_cnt
);

   localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam logic [5:0]       BI_LAST  = 6'(HDR_BYTES - 1);
   localparam logic [ADDR_W-1:0] SI_LAST = ADDR_W'(SAMPLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   state_t              state, state_nx;
   logic [SHADOW_W-1:0] shadow;
   logic [5:0]          bi;
   logic [ADDR_W-1:0]   si;
   logic [BYTE_W-1:0]   byte_q;
   logic [15:0]         frame_q;
   logic                gap_load, gap_exp;

   gap_timer #(.W(GAP_W)) u_gap (
      .clk      (clk),
      .rst_n    (c10_resetn),
      .load     (gap_load),
      .load_val (GAP_LOAD),
      .expire   (gap_exp)
   );

   always_ff @(posedge clk or negedge c10_resetn) begin
      if (!c10_resetn) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      gap_load = 1'b0;
      case (state)
         IDLE:     if (start) state_nx = HDR_SEND;
         HDR_SEND: state_nx = HDR_WAIT;
         HDR_WAIT: if (uart.tx_done) state_nx = (bi == BI_LAST) ? SEN_ADDR : HDR_SEND;
         SEN_ADDR: state_nx = SEN_SEND;
         SEN_SEND: state_nx = SEN_WAIT;
         SEN_WAIT: if (uart.tx_done) begin
            if (si == SI_LAST) begin
               gap_load = 1'b1;
               state_nx = GAP;
            end else begin
               state_nx = SEN_ADDR;
            end
         end
         GAP:      if (gap_exp) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge c10_resetn) begin
      if (!c10_resetn) begin
         shadow  <= '0;
         bi      <= '0;
         si      <= '0;
         byte_q  <= '0;
         frame_q <= '0;
      end else begin
         if (state == IDLE && start) begin
            shadow[SHADOW_W-1-FLD_PT*FIELD_W  -: FIELD_W] <= pt;
            shadow[SHADOW_W-1-FLD_KEY*FIELD_W -: FIELD_W] <= key;
            shadow[SHADOW_W-1-FLD_CT*FIELD_W  -: FIELD_W] <= ct;
            bi <= '0;
         end
         if (state == HDR_WAIT && uart.tx_done) begin
            if (bi == BI_LAST) si <= '0;
            else               bi <= bi + 6'd1;
         end
         if (state == SEN_WAIT && uart.tx_done && si != SI_LAST)
            si <= si + ADDR_W'(1);
         // Hold the last sent byte so tx_byte stays stable between pulses
         if (uart.tx_dv) byte_q <= uart.tx_byte;
         if (done)       frame_q <= frame_q + 16'd1;
      end
   end

   // Sample bytes pass straight through: mem_rdata is only valid in SEN_SEND
   always_comb begin
      uart.tx_byte = byte_q;
      case (state)
         HDR_SEND: uart.tx_byte = hdr_byte(shadow, bi);
         SEN_SEND: uart.tx_byte = mem_rdata;
         default:  ;
      endcase
   end

   assign uart.tx_dv = (state == HDR_SEND) || (state == SEN_SEND);
   assign done       = (state == GAP) && gap_exp;
   assign busy       = (state != IDLE) && !done;
   assign mem_addr   = si;
   assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_trace_tx_sequencer.sv
// Directed bench for trace_tx_sequencer: scoreboard of expected bytes checked on every tx_dv.
module tb_trace_tx_sequencer;

   localparam int SAMPLES = 4;
   localparam int ADDR_W  = 2;
   localparam int GAP     = 8;
   localparam int FRAME   = 48 + SAMPLES;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start = 1'b0;
   logic [127:0]       pt = '0, key = '0, ct = '0;
   logic [ADDR_W-1:0]  mem_addr;
   logic [7:0]         mem_rdata;
   logic               busy, done;
   logic [15:0]        frame_cnt;
   logic [7:0]         mem [SAMPLES];
   logic               uart_done = 1'b0;
   logic               spur = 1'b0;
   logic               spur_gap = 1'b0;
   logic               prev_dv = 1'b0;
   logic [7:0]         sbq [$];
   int                 tests = 0, fails = 0;
   int                 cyc = 0, cd = 0, frame_pulses = 0, last_td = 0, done_cyc = 0;

   trace_tx_sequencer_if u_if ();
   assign u_if.tx_done = uart_done | spur;

   always #5 clk = ~clk;

   always_ff @(posedge clk) mem_rdata <= mem[mem_addr];

   trace_tx_sequencer #(
      .SAMPLES    (SAMPLES),
      .ADDR_W     (ADDR_W),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk        (clk),
      .c10_resetn (rstn),
      .start      (start),
      .pt         (pt),
      .key        (key),
      .ct         (ct),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .uart       (u_if),
      .busy       (busy),
      .done       (done),
      .frame_cnt  (frame_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c);
      for (int i = 0; i < 16; i++) sbq.push_back(p[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) sbq.push_back(k[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) sbq.push_back(c[127-8*i -: 8]);
      for (int i = 0; i < SAMPLES; i++) sbq.push_back(mem[i]);
   endtask

   // One cycle: UART model (tx_done 3 cycles after tx_dv) plus scoreboard check.
   task automatic tick();
      @(negedge clk);
      cyc++;
      uart_done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            uart_done = 1'b1;
            last_td = cyc;
         end
      end
      spur = spur_gap && frame_pulses == FRAME && cd == 0 && cyc == last_td + 3;
      if (u_if.tx_dv) begin
         frame_pulses++;
         chk("dv_back2back", prev_dv, 0);
         cd = 3;
         if (sbq.size() == 0) chk("dv_extra", u_if.tx_dv, 0);
         else                 chk("tx_byte", u_if.tx_byte, sbq.pop_front());
      end
      prev_dv = u_if.tx_dv;
      if (done) done_cyc = cyc;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < bound);
      chk("done_seen", done, 1);
   endtask

   task automatic wait_pulses(input int want, input int bound);
      int n = 0;
      while (frame_pulses < want && n < bound) begin
         tick();
         n++;
      end
      chk("pulse_wait", frame_pulses, want);
   endtask

   task automatic pulse_start();
      frame_pulses = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < SAMPLES; i++) mem[i] = 8'hA0 + 8'(i);

      repeat (3) tick();
      chk("rst_busy",      busy, 0);
      chk("rst_done",      done, 0);
      chk("rst_tx_dv",     u_if.tx_dv, 0);
      chk("rst_tx_byte",   u_if.tx_byte, 0);
      chk("rst_mem_addr",  mem_addr, 0);
      chk("rst_frame_cnt", frame_cnt, 0);

      rstn = 1'b1;
      frame_pulses = 0;
      repeat (100) tick();
      chk("idle_no_dv", frame_pulses, 0);

      spur = 1'b1;
      repeat (6) tick();
      chk("idle_spur_busy", busy, 0);
      chk("idle_spur_dv", frame_pulses, 0);

      // Full frame with a spurious tx_done injected in the gap
      pt  = 128'h000102030405060708090A0B0C0D0E0F;
      key = 128'h101112131415161718191A1B1C1D1E1F;
      ct  = 128'h202122232425262728292A2B2C2D2E2F;
      push_frame(pt, key, ct);
      spur_gap = 1'b1;
      pulse_start();
      chk("first_dv", u_if.tx_dv, 1);
      chk("busy_on", busy, 1);
      wait_done(2000);
      spur_gap = 1'b0;
      chk("done_after_gap", done_cyc - last_td, GAP);
      chk("frame_pulses", frame_pulses, FRAME);
      chk("busy_at_done", busy, 0);
      chk("sb_drained", sbq.size(), 0);
      tick();
      chk("frame_cnt_1", frame_cnt, 1);
      chk("done_one_cycle", done, 0);

      // Snapshot: inputs and start change mid-header, frame must be unaffected
      pt  = 128'hC3C2C1C0B7B6B5B4A9A8A7A6A5A4A3A2;
      key = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      ct  = 128'h55AA55AA0123456789ABCDEFFEDCBA98;
      push_frame(pt, key, ct);
      pulse_start();
      wait_pulses(6, 200);
      pt = '1;
      key = '1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(2000);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("frame_cnt_2", frame_cnt, 2);
      chk("b2b_start_dv", u_if.tx_dv, 0);
      chk("b2b_start_busy", busy, 0);
      repeat (10) tick();
      chk("single_frame", frame_pulses, FRAME);
      chk("sb_drained_2", sbq.size(), 0);

      // Reset in the middle of the sample phase
      pt = 128'h11223344556677889900AABBCCDDEEFF;
      push_frame(pt, key, ct);
      pulse_start();
      wait_pulses(51, 400);
      rstn = 1'b0;
      #1;
      chk("midrst_tx_dv", u_if.tx_dv, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      chk("midrst_mem_addr", mem_addr, 0);
      sbq.delete();
      cd = 0;
      uart_done = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      frame_pulses = 0;
      repeat (5) tick();
      chk("no_resume", frame_pulses, 0);

      pt = 128'h5A000000000000000000000000000001;
      push_frame(pt, key, ct);
      pulse_start();
      chk("post_rst_first", u_if.tx_byte, 8'h5A);
      wait_done(2000);
      tick();
      chk("post_rst_frame_cnt", frame_cnt, 1);

      // Counter wrap from a preloaded 0xFFFF
      force dut.frame_q = 16'hFFFF;
      tick();
      release dut.frame_q;
      tick();
      chk("preload_ffff", frame_cnt, 16'hFFFF);
      push_frame(pt, key, ct);
      pulse_start();
      wait_done(2000);
      tick();
      chk("frame_cnt_wrap", frame_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
